ym_phase_gen: RTL

- Generates the two-phase enable pair (c1, c2) consumed by every shift-register, latch and counter cell in the chip core.
- Also provides the slot counter, the slot sync and a synchronised, flush-stretched chip reset (ic_out).
- Sits between the MCLK/IC pins and all downstream c1/c2 logic.
- Single clock domain (MCLK); c1/c2 are clock enables, not clocks.

---
 rtl/ym_phase_gen.sv | 114 +++++++++++
 1 files changed

// File: rtl/ym_phase_gen.sv
// Two-phase enable generator (c1/c2), slot counter and flush-stretched core reset.
// Everything runs on MCLK; c1 and c2 are single-cycle enables, not clocks.
//
// ic_out FSM
//   state    | meaning
//   ST_FLUSH | core held in reset; releases at the first slot wrap after ic_lat clears
//   ST_RUN   | normal operation, ic_out low
module ym_phase_gen #(
    parameter int DIV        = 6,
    parameter int SLOTS      = 24,
    parameter int SLOT_WIDTH = 5
) (
    input  logic                  MCLK,
    input  logic                  reset,
    input  logic                  ic_n,
    output logic                  c1,
    output logic                  c2,
    output logic [SLOT_WIDTH-1:0] slot,
    output logic                  slot_sync,
    output logic                  ic_out
);

    localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]         D_LAST    = DW'(DIV - 1);
    localparam logic [DW-1:0]         D_C2      = DW'(DIV / 2 - 1);
    localparam logic [SLOT_WIDTH-1:0] SLOT_LAST = SLOT_WIDTH'(SLOTS - 1);

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } ic_state_t;

    logic [DW-1:0] d;
    logic          ic_m;
    logic          ic_s;
    logic          ic_lat;
    ic_state_t     state;
    ic_state_t     state_nxt;

    // Enables are registered decodes of the divider, so c1 is high while d == 0
    // and c2 while d == DIV/2; they can never overlap.
    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            d  <= D_LAST;
            c1 <= 1'b0;
            c2 <= 1'b0;
        end else begin
            d  <= (d == D_LAST) ? '0 : d + 1'b1;
            c1 <= (d == D_LAST);
            c2 <= (d == D_C2);
        end
    end

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            ic_m <= 1'b1;
            ic_s <= 1'b1;
        end else begin
            ic_m <= ic_n;
            ic_s <= ic_m;
        end
    end

    // Sampling only on c1 edges filters ic_n glitches that fall between them.
    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            ic_lat <= 1'b1;
        end else if (c1) begin
            ic_lat <= ~ic_s;
        end
    end

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            slot <= '0;
        end else if (c2) begin
            if (ic_lat) begin
                slot <= '0;
            end else begin
                slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
            end
        end
    end

    assign slot_sync = (slot == '0);

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            state <= ST_FLUSH;
        end else begin
            state <= state_nxt;
        end
    end

    // IC has priority over the wrap, so a reassert mid-flush restarts the count.
    always_comb begin
        state_nxt = state;
        if (c2) begin
            if (ic_lat) begin
                state_nxt = ST_FLUSH;
            end else if ((state == ST_FLUSH) && (slot == SLOT_LAST)) begin
                state_nxt = ST_RUN;
            end
        end
    end

    always_comb begin
        ic_out = 1'b0;
        if (state == ST_FLUSH) begin
            ic_out = 1'b1;
        end
    end

endmodule
